// File: rtl/tree_ni_pkg.sv
// Shared definitions for the tree-leaf network interface:
// packet field offsets and the inject/eject handshake states.
package tree_ni_pkg;

    localparam int DEST_MSB  = 13;
    localparam int DEST_LSB  = 11;
    localparam int SRC_MSB   = 10;
    localparam int SRC_LSB   = 8;
    localparam int PAYLOAD_W = 8;

    typedef enum logic [1:0] {
        T_IDLE,
        T_REQ,
        T_REL
    } tx_state_t;

    typedef enum logic {
        R_IDLE,
        R_ACK
    } rx_state_t;

endpackage

// File: rtl/ni_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// Push while full and pop while empty are ignored.
module ni_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/tree_leaf_ni.sv
// Leaf network interface: PE valid/ready on one side, 4-phase
// bundled-data channels into and out of the tree on the other.
import tree_ni_pkg::*;

module tree_leaf_ni #(
    parameter int                    WIDTH_packet = 14,
    parameter int                    WIDTH_dest   = 3,
    parameter int                    WIDTH_addr   = 3,
    parameter logic [WIDTH_addr-1:0] ADDR         = 3'b000,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pe_tx_valid,
    output logic                    pe_tx_ready,
    input  logic [WIDTH_dest-1:0]   pe_tx_dest,
    input  logic [PAYLOAD_W-1:0]    pe_tx_payload,
    output logic                    pe_rx_valid,
    input  logic                    pe_rx_ready,
    output logic [WIDTH_addr-1:0]   pe_rx_src,
    output logic [PAYLOAD_W-1:0]    pe_rx_payload,
    output logic                    net_out_req,
    input  logic                    net_out_ack,
    output logic [WIDTH_packet-1:0] net_out_data,
    input  logic                    net_in_req,
    output logic                    net_in_ack,
    input  logic [WIDTH_packet-1:0] net_in_data,
    output logic [15:0]             tx_count,
    output logic [15:0]             rx_count,
    output logic                    err_misroute
);

    localparam int RXW = WIDTH_addr + PAYLOAD_W;

    logic                    ack_s1_q, ack_sync_q;
    logic                    req_s1_q, req_sync_q;
    logic                    live_q;
    tx_state_t               tx_state_q;
    rx_state_t               rx_state_q;
    logic                    out_req_q;
    logic [WIDTH_packet-1:0] out_data_q;
    logic                    in_ack_q;
    logic [15:0]             tx_cnt_q, rx_cnt_q;
    logic                    err_q;

    logic                    tx_full, tx_empty, tx_push, tx_pop;
    logic [WIDTH_packet-1:0] tx_head;
    logic                    rx_full, rx_empty, rx_push, rx_pop;
    logic                    rx_hit, dest_ok;
    logic [RXW-1:0]          rx_head;

    // Incoming handshake wires are asynchronous to clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_s1_q   <= 1'b0;
            ack_sync_q <= 1'b0;
            req_s1_q   <= 1'b0;
            req_sync_q <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            ack_s1_q   <= net_out_ack;
            ack_sync_q <= ack_s1_q;
            req_s1_q   <= net_in_req;
            req_sync_q <= req_s1_q;
            live_q     <= 1'b1;
        end
    end

    assign pe_tx_ready = live_q && !tx_full;
    assign tx_push     = pe_tx_valid && pe_tx_ready;
    assign tx_pop      = (tx_state_q == T_REL) && !ack_sync_q;

    ni_sync_fifo #(.WIDTH(WIDTH_packet), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (tx_push),
        .data_i ({pe_tx_dest, ADDR, pe_tx_payload}),
        .pop_i  (tx_pop),
        .head_o (tx_head),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= T_IDLE;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            tx_cnt_q   <= '0;
        end else begin
            unique case (tx_state_q)
                T_IDLE: if (!tx_empty) begin
                    out_data_q <= tx_head;
                    out_req_q  <= 1'b1;
                    tx_state_q <= T_REQ;
                end
                T_REQ: if (ack_sync_q) begin
                    out_req_q  <= 1'b0;
                    tx_state_q <= T_REL;
                end
                T_REL: if (!ack_sync_q) begin
                    tx_cnt_q   <= tx_cnt_q + 16'd1;
                    tx_state_q <= T_IDLE;
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    assign dest_ok = (net_in_data[DEST_MSB:DEST_LSB] == ADDR);
    assign rx_hit  = (rx_state_q == R_IDLE) && req_sync_q && !rx_full;
    assign rx_push = rx_hit && dest_ok;
    assign rx_pop  = pe_rx_valid && pe_rx_ready;

    ni_sync_fifo #(.WIDTH(RXW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (rx_push),
        .data_i (net_in_data[SRC_MSB:0]),
        .pop_i  (rx_pop),
        .head_o (rx_head),
        .full_o (rx_full),
        .empty_o(rx_empty)
    );

    // Misrouted packets are still acked so the tree never stalls on them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            in_ack_q   <= 1'b0;
            rx_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (rx_state_q)
                R_IDLE: if (rx_hit) begin
                    in_ack_q   <= 1'b1;
                    rx_state_q <= R_ACK;
                    if (dest_ok) rx_cnt_q <= rx_cnt_q + 16'd1;
                    else         err_q    <= 1'b1;
                end
                R_ACK: if (!req_sync_q) begin
                    in_ack_q   <= 1'b0;
                    rx_state_q <= R_IDLE;
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    assign pe_rx_valid   = !rx_empty;
    assign pe_rx_src     = rx_head[SRC_MSB:SRC_LSB];
    assign pe_rx_payload = rx_head[PAYLOAD_W-1:0];
    assign net_out_req   = out_req_q;
    assign net_out_data  = out_data_q;
    assign net_in_ack    = in_ack_q;
    assign tx_count      = tx_cnt_q;
    assign rx_count      = rx_cnt_q;
    assign err_misroute  = err_q;

endmodule

// File: tb/tb_tree_leaf_ni.sv
// Directed bench for tree_leaf_ni at ADDR=2: vector tables for the
// inject and eject paths plus hand sequences for backpressure and reset.
module tb_tree_leaf_ni;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pe_tx_valid = 1'b0;
    logic        pe_tx_ready;
    logic [2:0]  pe_tx_dest = '0;
    logic [7:0]  pe_tx_payload = '0;
    logic        pe_rx_valid;
    logic        pe_rx_ready = 1'b0;
    logic [2:0]  pe_rx_src;
    logic [7:0]  pe_rx_payload;
    logic        net_out_req;
    logic        net_out_ack = 1'b0;
    logic [13:0] net_out_data;
    logic        net_in_req = 1'b0;
    logic        net_in_ack;
    logic [13:0] net_in_data = '0;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic        err_misroute;

    int vecs = 0;
    int errs = 0;
    int accepted = 0;

    typedef struct {
        logic [2:0]  dest;
        logic [7:0]  pay;
        logic [13:0] exp_data;
    } txv_t;

    typedef struct {
        logic [2:0] dest;
        logic [2:0] src;
        logic [7:0] pay;
        logic       exp_valid;
        logic       exp_err;
    } rxv_t;

    txv_t tx_tbl [5];
    rxv_t rx_tbl [5];

    tree_leaf_ni #(.ADDR(3'd2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pe_tx_valid  (pe_tx_valid),
        .pe_tx_ready  (pe_tx_ready),
        .pe_tx_dest   (pe_tx_dest),
        .pe_tx_payload(pe_tx_payload),
        .pe_rx_valid  (pe_rx_valid),
        .pe_rx_ready  (pe_rx_ready),
        .pe_rx_src    (pe_rx_src),
        .pe_rx_payload(pe_rx_payload),
        .net_out_req  (net_out_req),
        .net_out_ack  (net_out_ack),
        .net_out_data (net_out_data),
        .net_in_req   (net_in_req),
        .net_in_ack   (net_in_ack),
        .net_in_data  (net_in_data),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .err_misroute (err_misroute)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic tx_push(input logic [2:0] d, input logic [7:0] p);
        int n = 0;
        pe_tx_valid   = 1'b1;
        pe_tx_dest    = d;
        pe_tx_payload = p;
        while (!pe_tx_ready && n < 200) begin
            tick();
            n++;
        end
        chk("tx_push_ready", pe_tx_ready, 1);
        tick();
        accepted++;
        pe_tx_valid = 1'b0;
    endtask

    // Plays the router's input channel for one packet.
    task automatic tx_hs(input logic [13:0] exp, input int dly,
                         input string nm);
        int n = 0;
        logic stable = 1'b1;
        while (!net_out_req && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_req_rise"}, net_out_req, 1);
        chk({nm, "_data"}, net_out_data, exp);
        repeat (dly) begin
            tick();
            if (net_out_data !== exp || !net_out_req) stable = 1'b0;
        end
        net_out_ack = 1'b1;
        n = 0;
        while (net_out_req && n < 100) begin
            tick();
            if (net_out_data !== exp) stable = 1'b0;
            n++;
        end
        chk({nm, "_req_fall"}, net_out_req, 0);
        net_out_ack = 1'b0;
        repeat (2) begin
            tick();
            if (net_out_data !== exp) stable = 1'b0;
        end
        chk({nm, "_stable"}, stable, 1);
    endtask

    // Plays the router's output channel for one packet.
    task automatic rx_send(input logic [2:0] d, input logic [2:0] s,
                           input logic [7:0] p, input string nm);
        int n = 0;
        net_in_data = {d, s, p};
        net_in_req  = 1'b1;
        while (!net_in_ack && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_ack_rise"}, net_in_ack, 1);
        net_in_req = 1'b0;
        n = 0;
        while (net_in_ack && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_ack_fall"}, net_in_ack, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int exp_rx;

        tx_tbl[0] = '{3'd5, 8'hA7, 14'b101_010_10100111};
        tx_tbl[1] = '{3'd2, 8'h00, 14'b010_010_00000000};
        tx_tbl[2] = '{3'd7, 8'hFF, 14'b111_010_11111111};
        tx_tbl[3] = '{3'd0, 8'h5A, 14'b000_010_01011010};
        tx_tbl[4] = '{3'd1, 8'h3C, 14'b001_010_00111100};

        rx_tbl[0] = '{3'd2, 3'd6, 8'h3C, 1'b1, 1'b0};
        rx_tbl[1] = '{3'd2, 3'd0, 8'h01, 1'b1, 1'b0};
        rx_tbl[2] = '{3'd2, 3'd7, 8'hFE, 1'b1, 1'b0};
        rx_tbl[3] = '{3'd7, 3'd1, 8'h99, 1'b0, 1'b1};
        rx_tbl[4] = '{3'd2, 3'd3, 8'h44, 1'b1, 1'b1};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_out_req", net_out_req, 0);
        chk("rst_out_data", net_out_data, 0);
        chk("rst_in_ack", net_in_ack, 0);
        chk("rst_tx_ready", pe_tx_ready, 0);
        chk("rst_rx_valid", pe_rx_valid, 0);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_err", err_misroute, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_tx_ready", pe_tx_ready, 1);

        // Inject path, one packet at a time
        for (int i = 0; i < 5; i++) begin
            tx_push(tx_tbl[i].dest, tx_tbl[i].pay);
            tx_hs(tx_tbl[i].exp_data, 3, "tx_tbl");
            tick();
            chk("tx_tbl_count", tx_count, i + 1);
        end

        // Eject path, including a misroute that stays sticky
        exp_rx = 0;
        for (int i = 0; i < 5; i++) begin
            rx_send(rx_tbl[i].dest, rx_tbl[i].src, rx_tbl[i].pay, "rx_tbl");
            tick();
            if (rx_tbl[i].exp_valid) exp_rx++;
            chk("rx_tbl_valid", pe_rx_valid, rx_tbl[i].exp_valid);
            chk("rx_tbl_count", rx_count, exp_rx);
            chk("rx_tbl_err", err_misroute, rx_tbl[i].exp_err);
            if (rx_tbl[i].exp_valid) begin
                chk("rx_tbl_src", pe_rx_src, rx_tbl[i].src);
                chk("rx_tbl_pay", pe_rx_payload, rx_tbl[i].pay);
                pe_rx_ready = 1'b1;
                tick();
                pe_rx_ready = 1'b0;
                chk("rx_tbl_pop", pe_rx_valid, 0);
            end
        end
        repeat (5) tick();
        chk("err_sticky", err_misroute, 1);
        do_reset();
        chk("err_cleared", err_misroute, 0);

        // Six pushes with ack withheld: FIFO fills at four
        accepted = 0;
        fork
            begin : pusher
                for (int i = 0; i < 6; i++)
                    tx_push(3'(i), 8'h10 + 8'(i));
            end
            begin : router
                int m = 0;
                while (accepted < 4 && m < 200) begin
                    tick();
                    m++;
                end
                repeat (3) tick();
                chk("t3_accepted", accepted, 4);
                chk("t3_full", pe_tx_ready, 0);
                for (int i = 0; i < 6; i++)
                    tx_hs({3'(i), 3'd2, 8'h10 + 8'(i)}, 1, "t3_hs");
            end
        join
        tick();
        chk("t3_count", tx_count, 6);
        chk("t3_ready", pe_tx_ready, 1);

        // RX FIFO full: fifth request waits for a PE pop
        do_reset();
        pe_rx_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            rx_send(3'd2, 3'(i), 8'hC0 + 8'(i), "t4_rx");
        tick();
        chk("t4_count4", rx_count, 4);
        net_in_data = {3'd2, 3'd4, 8'hC4};
        net_in_req  = 1'b1;
        repeat (10) tick();
        chk("t4_bp_hold", net_in_ack, 0);
        chk("t4_head_src", pe_rx_src, 0);
        chk("t4_head_pay", pe_rx_payload, 8'hC0);
        pe_rx_ready = 1'b1;
        tick();
        pe_rx_ready = 1'b0;
        n = 0;
        while (!net_in_ack && n < 100) begin
            tick();
            n++;
        end
        chk("t4_late_ack", net_in_ack, 1);
        net_in_req = 1'b0;
        n = 0;
        while (net_in_ack && n < 100) begin
            tick();
            n++;
        end
        chk("t4_ack_fall", net_in_ack, 0);
        chk("t4_count5", rx_count, 5);
        for (int i = 1; i < 5; i++) begin
            chk("t4_drain_valid", pe_rx_valid, 1);
            chk("t4_drain_src", pe_rx_src, i);
            chk("t4_drain_pay", pe_rx_payload, 8'hC0 + 8'(i));
            pe_rx_ready = 1'b1;
            tick();
            pe_rx_ready = 1'b0;
        end
        chk("t4_empty", pe_rx_valid, 0);

        // Reset in the middle of both handshakes
        tx_push(3'd3, 8'h11);
        tx_push(3'd4, 8'h12);
        net_in_data = {3'd2, 3'd5, 8'h22};
        net_in_req  = 1'b1;
        n = 0;
        while (!(net_out_req && net_in_ack) && n < 100) begin
            tick();
            n++;
        end
        chk("t6_pre_req", net_out_req, 1);
        chk("t6_pre_ack", net_in_ack, 1);
        chk("t6_pre_rxcnt", rx_count, 6);
        rst_n = 1'b0;
        tick();
        chk("t6_req", net_out_req, 0);
        chk("t6_ack", net_in_ack, 0);
        chk("t6_data", net_out_data, 0);
        chk("t6_tx_ready", pe_tx_ready, 0);
        chk("t6_rx_valid", pe_rx_valid, 0);
        chk("t6_tx_count", tx_count, 0);
        chk("t6_rx_count", rx_count, 0);
        net_in_req = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t6_ready_back", pe_tx_ready, 1);
        chk("t6_tx_empty", net_out_req, 0);
        chk("t6_rx_empty", pe_rx_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
